m_operand_stage: RTL and testbench

- Execute-stage operand fetch and issue block that feeds the ALU.
- Holds the 32-entry register file (x0 hardwired to zero) and reads two source operands per accepted instruction.
- Optionally substitutes an immediate for operand 1.
- Presents `{d0, d1, ctl, rd}` to the ALU through a valid/ready interface with a 2-entry skid buffer.
- Held entries snoop the writeback port so a stalled operand never goes stale.

---
 rtl/m_operand_stage_pkg.sv | 29 ++
 rtl/m_operand_stage_regfile.sv | 36 +++
 rtl/m_operand_stage.sv | 137 +++++++++++++
 tb/tb_m_operand_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/m_operand_stage_pkg.sv
// Shared types and constants for the execute-stage operand fetch/issue block.
package m_operand_stage_pkg;

    localparam int DATA_W = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int REG_IW = $clog2(NREG_DEFAULT);

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;

    // One buffered instruction: operands plus the source indices needed to snoop writebacks.
    typedef struct packed {
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [1:0]        ctl;
        logic [REG_IW-1:0] rd;
        logic [REG_IW-1:0] rs1;
        logic [REG_IW-1:0] rs2;
        logic              use_imm;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/m_operand_stage_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 reads zero.
module m_regfile
    import m_operand_stage_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_IW-1:0] i_ra0,
    input  logic [REG_IW-1:0] i_ra1,
    output logic [W-1:0]      o_rd0,
    output logic [W-1:0]      o_rd1,
    input  logic              i_we,
    input  logic [REG_IW-1:0] i_wa,
    input  logic [W-1:0]      i_wd
);

    logic [W-1:0] regs [NREG];

    // Write port; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (i_we && (i_wa != '0)) begin
            regs[i_wa] <= i_wd;
        end
    end

    // Read ports return the stored value; x0 is forced to zero explicitly.
    always_comb begin
        o_rd0 = (i_ra0 == '0) ? '0 : regs[i_ra0];
        o_rd1 = (i_ra1 == '0) ? '0 : regs[i_ra1];
    end

endmodule

// File: rtl/m_operand_stage.sv
// Operand fetch and issue: reads two sources (with write bypass), optionally substitutes an
// immediate, and hands {d0, d1, ctl, rd} to the ALU through a 2-entry skid buffer whose held
// entries keep snooping the writeback port.
module m_operand_stage
    import m_operand_stage_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [REG_IW-1:0] i_rs1,
    input  logic [REG_IW-1:0] i_rs2,
    input  logic [REG_IW-1:0] i_rd,
    input  logic [1:0]        i_ctl,
    input  logic [W-1:0]      i_imm,
    input  logic              i_use_imm,
    input  logic              i_we,
    input  logic [REG_IW-1:0] i_wa,
    input  logic [W-1:0]      i_wd,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W-1:0]      o_d0,
    output logic [W-1:0]      o_d1,
    output logic [1:0]        o_ctl,
    output logic [REG_IW-1:0] o_rd
);

    buf_state_e state_q, state_n;
    entry_t     out_q, out_n;
    entry_t     skid_q, skid_n;
    entry_t     raw_ent, in_ent, out_snp, skid_snp;
    logic [W-1:0] rf_rd0, rf_rd1;
    logic       accept, issue;

    // Replace any operand whose source matches a nonzero writeback this cycle.
    function automatic entry_t snoop(input entry_t e, input logic we,
                                     input logic [REG_IW-1:0] wa, input logic [W-1:0] wd);
        entry_t r;
        r = e;
        if (we && (wa != '0)) begin
            if (e.rs1 == wa) r.d0 = wd;
            if (!e.use_imm && (e.rs2 == wa)) r.d1 = wd;
        end
        return r;
    endfunction

    m_regfile #(.W(W), .NREG(NREG)) u_regfile (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ra0   (i_rs1),
        .i_ra1   (i_rs2),
        .o_rd0   (rf_rd0),
        .o_rd1   (rf_rd1),
        .i_we    (i_we),
        .i_wa    (i_wa),
        .i_wd    (i_wd)
    );

    assign o_valid = (state_q != ST_EMPTY);
    // Derived purely from the state flops, so nothing from i_ready reaches it combinationally.
    assign o_ready = (state_q != ST_FULL);
    assign accept  = i_valid && o_ready;
    assign issue   = o_valid && i_ready;

    assign o_d0  = out_q.d0;
    assign o_d1  = out_q.d1;
    assign o_ctl = out_q.ctl;
    assign o_rd  = out_q.rd;

    // Build the incoming entry; snooping it gives the same-cycle read bypass for free.
    always_comb begin
        raw_ent         = '0;
        raw_ent.d0      = rf_rd0;
        raw_ent.d1      = i_use_imm ? i_imm : rf_rd1;
        raw_ent.ctl     = i_ctl;
        raw_ent.rd      = i_rd;
        raw_ent.rs1     = i_rs1;
        raw_ent.rs2     = i_rs2;
        raw_ent.use_imm = i_use_imm;
        in_ent          = snoop(raw_ent, i_we, i_wa, i_wd);
    end

    // Held entries with their writeback snoop applied; empty slots are left untouched.
    always_comb begin
        out_snp  = (state_q != ST_EMPTY) ? snoop(out_q, i_we, i_wa, i_wd) : out_q;
        skid_snp = (state_q == ST_FULL)  ? snoop(skid_q, i_we, i_wa, i_wd) : skid_q;
    end

    // Skid buffer next-state and entry movement.
    always_comb begin
        state_n = state_q;
        out_n   = out_snp;
        skid_n  = skid_snp;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_n   = in_ent;
                    state_n = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && issue) begin
                    out_n = in_ent;
                end else if (accept) begin
                    skid_n  = in_ent;
                    state_n = ST_FULL;
                end else if (issue) begin
                    state_n = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (issue) begin
                    out_n   = skid_snp;
                    state_n = ST_ONE;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // State and entry registers; reset discards both entries at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            out_q   <= out_n;
            skid_q  <= skid_n;
        end
    end

endmodule

// File: tb/tb_m_operand_stage.sv
// Self-checking bench: directed scenarios plus random traffic against an in-order queue model.
module tb_m_operand_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, o_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic [1:0]  i_ctl;
    logic [31:0] i_imm;
    logic        i_use_imm;
    logic        i_we;
    logic [4:0]  i_wa;
    logic [31:0] i_wd;
    logic        o_valid, i_ready;
    logic [31:0] o_d0, o_d1;
    logic [1:0]  o_ctl;
    logic [4:0]  o_rd;

    m_operand_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_ctl(i_ctl), .i_imm(i_imm),
        .i_use_imm(i_use_imm), .i_we(i_we), .i_wa(i_wa), .i_wd(i_wd),
        .o_valid(o_valid), .i_ready(i_ready), .o_d0(o_d0), .o_d1(o_d1),
        .o_ctl(o_ctl), .o_rd(o_rd)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] d0, d1;
        logic [1:0]  ctl;
        logic [4:0]  rd, rs1, rs2;
        logic        ui;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_iss = 0;
    bit          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        chk("valid", o_valid, q.size() != 0);
        chk("ready", o_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("d0",  o_d0,  q[0].d0);
            chk("d1",  o_d1,  q[0].d1);
            chk("ctl", o_ctl, q[0].ctl);
            chk("rd",  o_rd,  q[0].rd);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [1:0] ctl, input logic [31:0] imm,
                        input logic ui, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic rdy);
        exp_t e;
        bit acc, iss;
        i_valid = v; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_ctl = ctl; i_imm = imm;
        i_use_imm = ui; i_we = we; i_wa = wa; i_wd = wd; i_ready = rdy;
        acc = v && (q.size() < 2);
        iss = (q.size() > 0) && rdy;
        @(posedge i_clk);
        if (iss) begin
            void'(q.pop_front());
            n_iss++;
        end
        if (acc) begin
            e.d0  = mregs[rs1];
            e.d1  = ui ? imm : mregs[rs2];
            e.ctl = ctl; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.ui = ui;
            q.push_back(e);
        end
        // A write lands in every in-flight instruction that names it, including the new one.
        if (we && wa != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rs1 == wa) q[i].d0 = wd;
                if (!q[i].ui && q[i].rs2 == wa) q[i].d1 = wd;
            end
            mregs[wa] = wd;
        end
        last_acc = acc;
        #1;
        check_outs();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 32'd0, 1'b0, 1'b1, wa, wd, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() != 0; k++) idle(1'b1);
        chk("drained", q.size(), 0);
    endtask

    initial begin
        int k, cyc, base;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        i_rst_n = 1'b0;
        i_valid = 0; i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_ctl = 0; i_imm = 0;
        i_use_imm = 0; i_we = 0; i_wa = 0; i_wd = 0; i_ready = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_d0", o_d0, 32'd0);
        chk("rst_d1", o_d1, 32'd0);
        chk("rst_ctl", o_ctl, 2'd0);
        chk("rst_rd", o_rd, 5'd0);
        i_rst_n = 1'b1;

        // Basic read of two written registers.
        wr(5'd5, 32'h10);
        wr(5'd6, 32'h3);
        step(1'b1, 5'd5, 5'd6, 5'd1, 2'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("tp1_valid", o_valid, 1'b1);
        chk("tp1_d0", o_d0, 32'h10);
        chk("tp1_d1", o_d1, 32'h3);
        chk("tp1_ctl", o_ctl, 2'd1);
        // x0 write dropped, immediate substituted.
        step(1'b1, 5'd0, 5'd6, 5'd2, 2'd2, 32'hABCD, 1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b1);
        chk("x0_d0", o_d0, 32'd0);
        chk("imm_d1", o_d1, 32'hABCD);
        // Read bypass from a same-cycle write.
        step(1'b1, 5'd7, 5'd0, 5'd3, 2'd3, 32'd0, 1'b0, 1'b1, 5'd7, 32'h55, 1'b1);
        chk("byp_d0", o_d0, 32'h55);
        chk("ctl3_pass", o_ctl, 2'd3);
        drain();

        // Fill both entries while stalled, snoop a write, then drain in order.
        step(1'b1, 5'd5, 5'd6, 5'd4, 2'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 5'd6, 5'd5, 5'd5, 2'd1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("full_ready", o_ready, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h99, 1'b0);
        chk("snoop_out_d0", o_d0, 32'h99);
        idle(1'b1);
        chk("snoop_skid_rd", o_rd, 5'd5);
        chk("snoop_skid_d1", o_d1, 32'h99);
        idle(1'b1);
        chk("drain_ready", o_ready, 1'b1);
        chk("drain_valid", o_valid, 1'b0);

        // Stream 8 instructions against an alternating sink.
        base = n_iss; k = 0; cyc = 0;
        while (k < 8 && cyc < 100) begin
            step(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'(8 + k),
                 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 1'(cyc % 2));
            if (last_acc) k++;
            cyc++;
        end
        chk("stream_acc", k, 8);
        drain();
        chk("stream_iss", n_iss - base, 8);

        // Reset while full.
        step(1'b1, 5'd5, 5'd6, 5'd1, 2'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 5'd6, 5'd5, 5'd2, 2'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("pre_rst_ready", o_ready, 1'b0);
        i_valid = 1'b0; i_we = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_ready", o_ready, 1'b1);
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        #1 i_rst_n = 1'b1;
        step(1'b1, 5'd5, 5'd6, 5'd1, 2'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("postrst_d0", o_d0, 32'd0);
        chk("postrst_d1", o_d1, 32'd0);
        drain();

        // Random traffic with heavy register aliasing.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom), 2'($urandom), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
